// File: rtl/mbgd_hypothesis_seq.sv
// rtl/mbgd_hypothesis_seq.sv - mini-batch gradient descent hypothesis accumulator (h = sat((X * teta) >> SHIFT))
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start                  one-cycle request to begin a batch (honoured only in IDLE)
//   teta_vec [DW1*F]       parameter vector, latched on start
//   x_col [DW1*N]          one feature column, one element per sample lane
//   col_valid / col_ready  column handshake (ready only while accumulating)
//   h [DW1*N]              saturated hypothesis vector
//   h_valid / h_ready      result handshake
//   busy                   high whenever not IDLE
module mbgd_hypothesis_seq #(
    parameter int DW1   = 8,
    parameter int N     = 8,
    parameter int F     = 8,
    parameter int F_BIT = 3,
    parameter int SHIFT = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [DW1*F-1:0]   teta_vec,
    input  logic [DW1*N-1:0]   x_col,
    input  logic               col_valid,
    output logic               col_ready,
    output logic [DW1*N-1:0]   h,
    output logic               h_valid,
    input  logic               h_ready,
    output logic               busy
);

    // Sum of F products of two DW1-bit values never exceeds 2*DW1+F_BIT bits.
    localparam int ACC_W = 2*DW1 + F_BIT;
    localparam logic [ACC_W-1:0] SAT = ACC_W'((1 << DW1) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DW1-1:0]     teta_q [F];
    logic [ACC_W-1:0]   acc_q  [N];
    logic [ACC_W-1:0]   acc_d  [N];
    logic [F_BIT-1:0]   cnt_q;
    logic [DW1*N-1:0]   h_q, h_d;
    logic               load, accept, last;
    logic [2*DW1-1:0]   prod;
    logic [ACC_W-1:0]   shifted;

    assign h = h_q;

    // Next-state and handshake outputs; all outputs decode from the state only,
    // so reset forces them low immediately.
    always_comb begin
        state_d   = state_q;
        col_ready = 1'b0;
        h_valid   = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                col_ready = 1'b1;
                busy      = 1'b1;
                if (col_valid) begin
                    accept = 1'b1;
                    if (cnt_q == F_BIT'(F - 1)) begin
                        last    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                h_valid = 1'b1;
                busy    = 1'b1;
                if (h_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-lane multiply-accumulate and the saturated result of the updated sum,
    // so h can load on the same edge as the last column.
    always_comb begin
        h_d     = '0;
        prod    = '0;
        shifted = '0;
        for (int i = 0; i < N; i++) begin
            prod     = {{DW1{1'b0}}, x_col[i*DW1 +: DW1]} * {{DW1{1'b0}}, teta_q[cnt_q]};
            acc_d[i] = acc_q[i] + {{F_BIT{1'b0}}, prod};
            shifted  = acc_d[i] >> SHIFT;
            h_d[i*DW1 +: DW1] = (shifted > SAT) ? {DW1{1'b1}} : shifted[DW1-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < F; k++) begin
                teta_q[k] <= '0;
            end
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= '0;
            end
            cnt_q <= '0;
            h_q   <= '0;
        end else if (load) begin
            for (int k = 0; k < F; k++) begin
                teta_q[k] <= teta_vec[k*DW1 +: DW1];
            end
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= '0;
            end
            cnt_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                acc_q[i] <= acc_d[i];
            end
            cnt_q <= last ? '0 : cnt_q + F_BIT'(1);
            if (last) begin
                h_q <= h_d;
            end
        end
    end

endmodule
